// File: rtl/ttt_pkg.sv
// Shared types for the NxN tic-tac-toe engine: FSM states, cell and winner
// encodings, and the per-direction scan step table.
package ttt_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_MOVE = 2'd1,
    S_CHECK     = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  typedef logic [1:0] cell_t;

  localparam cell_t CELL_EMPTY = 2'd0;
  localparam cell_t CELL_P0    = 2'd1;
  localparam cell_t CELL_P1    = 2'd2;

  localparam logic [1:0] W_P0   = 2'd0;
  localparam logic [1:0] W_P1   = 2'd1;
  localparam logic [1:0] W_NONE = 2'd2;
  localparam logic [1:0] W_DRAW = 2'd3;

  // x is the row index, y the column index
  typedef enum logic [1:0] {
    DIR_ROW  = 2'd0,
    DIR_COL  = 2'd1,
    DIR_DIAG = 2'd2,
    DIR_ANTI = 2'd3
  } dir_t;

  function automatic int dir_dx(input dir_t d);
    case (d)
      DIR_ROW: return 0;
      default: return 1;
    endcase
  endfunction

  function automatic int dir_dy(input dir_t d);
    case (d)
      DIR_ROW:  return 1;
      DIR_COL:  return 0;
      DIR_DIAG: return 1;
      default:  return -1;
    endcase
  endfunction

  function automatic cell_t player_cell(input logic p);
    return p ? CELL_P1 : CELL_P0;
  endfunction

endpackage

// File: rtl/ttt_nxn_fsm_if.sv
// Move handshake between a move source (master) and the game engine (slave).
interface ttt_nxn_fsm_if #(
  parameter int unsigned N = 3
);
  localparam int unsigned CW = $clog2(N);

  logic          move_valid;
  logic          move_ready;
  logic          player;
  logic [CW-1:0] data_in_x;
  logic [CW-1:0] data_in_y;
  logic          move_err;

  modport master (
    output move_valid, player, data_in_x, data_in_y,
    input  move_ready, move_err
  );

  modport slave (
    input  move_valid, player, data_in_x, data_in_y,
    output move_ready, move_err
  );
endinterface

// File: rtl/ttt_board.sv
// NxN cell storage: one write port, one scan read port and a debug read port.
module ttt_board
  import ttt_pkg::*;
#(
  parameter  int unsigned N  = 3,
  localparam int unsigned CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          we,
  input  logic [CW-1:0] wr_x,
  input  logic [CW-1:0] wr_y,
  input  cell_t         wr_cell,
  input  logic [CW-1:0] scan_x,
  input  logic [CW-1:0] scan_y,
  output cell_t         scan_cell,
  input  logic [CW-1:0] rd_x,
  input  logic [CW-1:0] rd_y,
  output cell_t         rd_cell
);

  cell_t game_state [N][N];

  always_ff @(posedge clk or negedge reset) begin : p_store
    if (!reset) begin
      for (int i = 0; i < int'(N); i++)
        for (int j = 0; j < int'(N); j++)
          game_state[i][j] <= CELL_EMPTY;
    end else if (clear) begin
      for (int i = 0; i < int'(N); i++)
        for (int j = 0; j < int'(N); j++)
          game_state[i][j] <= CELL_EMPTY;
    end else if (we) begin
      game_state[wr_x][wr_y] <= wr_cell;
    end
  end

  // Off-board addresses read back as empty
  assign scan_cell = (32'(scan_x) < N && 32'(scan_y) < N) ? game_state[scan_x][scan_y]
                                                          : CELL_EMPTY;
  assign rd_cell   = (32'(rd_x) < N && 32'(rd_y) < N) ? game_state[rd_x][rd_y]
                                                      : CELL_EMPTY;

endmodule

// File: rtl/ttt_nxn_fsm.sv
// NxN, K-in-a-row game engine: validates moves, stores the board and scans the
// four lines through each placed cell one probe per cycle to detect a win.
module ttt_nxn_fsm
  import ttt_pkg::*;
#(
  parameter  int unsigned N  = 3,
  parameter  int unsigned K  = 3,
  localparam int unsigned CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          new_game,
  ttt_nxn_fsm_if.slave  mv,
  output logic          turn,
  output logic          busy,
  output logic [1:0]    winner,
  output logic          stop_game,
  input  logic [CW-1:0] rd_x,
  input  logic [CW-1:0] rd_y,
  output cell_t         rd_cell
);

  if (N < 3 || N > 8 || K < 3 || K > N) begin : g_bad_params
    $error("ttt_nxn_fsm: illegal parameters N=%0d K=%0d", N, K);
  end

  localparam int unsigned STW = $clog2(K);
  localparam int unsigned OCW = $clog2(N * N + 1);

  state_t         state_q,  state_d;
  logic           turn_q,   turn_d;
  logic [1:0]     winner_q, winner_d;
  logic [OCW-1:0] occ_q,    occ_d;
  logic           err_q,    err_d;
  logic           mover_q,  mover_d;
  logic [CW-1:0]  mx_q,     mx_d;
  logic [CW-1:0]  my_q,     my_d;
  dir_t           dir_q,    dir_d;
  logic           side_q,   side_d;
  logic [STW-1:0] step_q,   step_d;
  logic [STW-1:0] cnt_q,    cnt_d;

  int             probe_sgn;
  int             probe_x;
  int             probe_y;
  logic           probe_in;
  logic           probe_hit;
  logic [CW-1:0]  scan_x;
  logic [CW-1:0]  scan_y;
  cell_t          scan_cell;
  logic           ready_c;
  logic           illegal;
  logic           side_end;
  logic           we;
  logic           clr;

  // Probe cell: step_q cells from the placed cell along dir_q, side_q selects -/+
  always_comb begin : p_probe
    probe_sgn = side_q ? -1 : 1;
    probe_x   = int'(mx_q) + probe_sgn * dir_dx(dir_q) * int'(step_q);
    probe_y   = int'(my_q) + probe_sgn * dir_dy(dir_q) * int'(step_q);
    probe_in  = (probe_x >= 0) && (probe_x < int'(N)) && (probe_y >= 0) && (probe_y < int'(N));
  end

  // The scan port doubles as the occupancy lookup for an offered move
  assign scan_x    = (state_q == S_CHECK) ? CW'(probe_x) : mv.data_in_x;
  assign scan_y    = (state_q == S_CHECK) ? CW'(probe_y) : mv.data_in_y;
  assign probe_hit = probe_in && (scan_cell == player_cell(mover_q));

  assign ready_c = (state_q == S_WAIT_MOVE) && enable && !new_game;
  assign illegal = (32'(mv.data_in_x) >= N) || (32'(mv.data_in_y) >= N) ||
                   (scan_cell != CELL_EMPTY) || (mv.player != turn_q);

  ttt_board #(.N(N)) u_board (
    .clk      (clk),
    .reset    (reset),
    .clear    (clr),
    .we       (we),
    .wr_x     (mv.data_in_x),
    .wr_y     (mv.data_in_y),
    .wr_cell  (player_cell(mv.player)),
    .scan_x   (scan_x),
    .scan_y   (scan_y),
    .scan_cell(scan_cell),
    .rd_x     (rd_x),
    .rd_y     (rd_y),
    .rd_cell  (rd_cell)
  );

  // Next-state and datapath control
  always_comb begin : p_next
    state_d  = state_q;
    turn_d   = turn_q;
    winner_d = winner_q;
    occ_d    = occ_q;
    err_d    = 1'b0;
    mover_d  = mover_q;
    mx_d     = mx_q;
    my_d     = my_q;
    dir_d    = dir_q;
    side_d   = side_q;
    step_d   = step_q;
    cnt_d    = cnt_q;
    side_end = 1'b0;
    we       = 1'b0;
    clr      = 1'b0;

    if (new_game) begin
      clr      = 1'b1;
      state_d  = S_WAIT_MOVE;
      turn_d   = 1'b0;
      winner_d = W_NONE;
      occ_d    = '0;
    end else if (enable) begin
      unique case (state_q)
        S_IDLE: state_d = S_WAIT_MOVE;

        S_WAIT_MOVE: begin
          if (mv.move_valid && ready_c) begin
            if (illegal) begin
              err_d = 1'b1;
            end else begin
              we      = 1'b1;
              occ_d   = occ_q + OCW'(1);
              mover_d = mv.player;
              mx_d    = mv.data_in_x;
              my_d    = mv.data_in_y;
              dir_d   = DIR_ROW;
              side_d  = 1'b0;
              step_d  = STW'(1);
              cnt_d   = '0;
              state_d = S_CHECK;
            end
          end
        end

        S_CHECK: begin
          if (probe_hit) begin
            // cnt_q + 1 matched neighbours plus the placed cell
            if (int'(cnt_q) + 2 >= int'(K)) begin
              winner_d = mover_q ? W_P1 : W_P0;
              state_d  = S_DONE;
            end else begin
              cnt_d = cnt_q + STW'(1);
              if (int'(step_q) == int'(K) - 1) side_end = 1'b1;
              else                            step_d   = step_q + STW'(1);
            end
          end else begin
            side_end = 1'b1;
          end

          if (side_end) begin
            step_d = STW'(1);
            if (!side_q) begin
              side_d = 1'b1;
            end else if (dir_q != DIR_ANTI) begin
              dir_d  = dir_t'(dir_q + 2'd1);
              side_d = 1'b0;
              cnt_d  = '0;
            end else if (occ_q == OCW'(N * N)) begin
              winner_d = W_DRAW;
              state_d  = S_DONE;
            end else begin
              turn_d  = ~turn_q;
              state_d = S_WAIT_MOVE;
            end
          end
        end

        S_DONE: state_d = S_DONE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin : p_regs
    if (!reset) begin
      state_q  <= S_IDLE;
      turn_q   <= 1'b0;
      winner_q <= W_NONE;
      occ_q    <= '0;
      err_q    <= 1'b0;
      mover_q  <= 1'b0;
      mx_q     <= '0;
      my_q     <= '0;
      dir_q    <= DIR_ROW;
      side_q   <= 1'b0;
      step_q   <= STW'(1);
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      turn_q   <= turn_d;
      winner_q <= winner_d;
      occ_q    <= occ_d;
      err_q    <= err_d;
      mover_q  <= mover_d;
      mx_q     <= mx_d;
      my_q     <= my_d;
      dir_q    <= dir_d;
      side_q   <= side_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
    end
  end

  assign mv.move_ready = ready_c;
  assign mv.move_err   = err_q;
  assign turn          = turn_q;
  assign winner        = winner_q;
  assign busy          = (state_q == S_CHECK);
  assign stop_game     = (state_q == S_DONE);

endmodule

// File: tb/tb_ttt_nxn_fsm.sv
// Scoreboard bench: a 5x5/K=4 engine for wins, illegal moves, enable and reset,
// plus a 3x3/K=3 engine for the draw.
module tb_ttt_nxn_fsm;
  import ttt_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst5_n, en5, ng5, turn5, busy5, stop5;
  logic [1:0] win5;
  logic [2:0] rdx5, rdy5;
  cell_t      rdc5;
  logic       rst3_n, en3, ng3, turn3, busy3, stop3;
  logic [1:0] win3;
  logic [1:0] rdx3, rdy3;
  cell_t      rdc3;

  ttt_nxn_fsm_if #(.N(5)) mif5 ();
  ttt_nxn_fsm_if #(.N(3)) mif3 ();

  ttt_nxn_fsm #(.N(5), .K(4)) u_dut5 (
    .clk(clk), .reset(rst5_n), .enable(en5), .new_game(ng5), .mv(mif5),
    .turn(turn5), .busy(busy5), .winner(win5), .stop_game(stop5),
    .rd_x(rdx5), .rd_y(rdy5), .rd_cell(rdc5)
  );

  ttt_nxn_fsm #(.N(3), .K(3)) u_dut3 (
    .clk(clk), .reset(rst3_n), .enable(en3), .new_game(ng3), .mv(mif3),
    .turn(turn3), .busy(busy3), .winner(win3), .stop_game(stop3),
    .rd_x(rdx3), .rd_y(rdy3), .rd_cell(rdc3)
  );

  typedef struct {
    string      name;
    bit         is_err;
    logic [1:0] winner;
    bit         stop;
    bit         turn;
    int         max_busy;
  } exp_t;

  exp_t sb5 [$];
  exp_t sb3 [$];
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt [2];
  bit   busy_prev [2];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a move ends with a move_err pulse or with busy falling
  task automatic observe(input int d, input bit rn, input bit en, input bit bsy,
                         input bit err, input logic [1:0] win, input bit stp, input bit trn);
    exp_t e;
    if (!rn) begin
      busy_prev[d] = 1'b0;
      busy_cnt[d]  = 0;
      return;
    end
    if (bsy && en) busy_cnt[d]++;
    if (err || (busy_prev[d] && !bsy)) begin
      if ((d == 0 ? sb5.size() : sb3.size()) == 0) begin
        chk($sformatf("dut%0d_unexpected_event", d), 1, 0);
      end else begin
        e = (d == 0) ? sb5.pop_front() : sb3.pop_front();
        chk({e.name, ".move_err"}, int'(err), int'(e.is_err));
        chk({e.name, ".winner"}, int'(win), int'(e.winner));
        chk({e.name, ".stop_game"}, int'(stp), int'(e.stop));
        chk({e.name, ".turn"}, int'(trn), int'(e.turn));
        if (!e.is_err) begin
          checks++;
          if (busy_cnt[d] > e.max_busy) begin
            errors++;
            $display("FAIL %s.busy_cycles: got %0d limit %0d", e.name, busy_cnt[d], e.max_busy);
          end
        end
      end
      busy_cnt[d] = 0;
    end
    busy_prev[d] = bsy;
  endtask

  always @(negedge clk) begin
    observe(0, rst5_n, en5, busy5, mif5.move_err, win5, stop5, turn5);
    observe(1, rst3_n, en3, busy3, mif3.move_err, win3, stop3, turn3);
  end

  function automatic bit rdy(input int d);
    return (d == 0) ? mif5.move_ready : mif3.move_ready;
  endfunction

  function automatic bit bsy(input int d);
    return (d == 0) ? busy5 : busy3;
  endfunction

  task automatic send_move(input int d, input bit p, input int x, input int y,
                           input bit push, input exp_t e);
    bit ok = 1'b0;
    if (push) begin
      if (d == 0) sb5.push_back(e);
      else        sb3.push_back(e);
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rdy(d)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk({e.name, ".ready_timeout"}, 0, 1);
      return;
    end
    if (d == 0) begin
      mif5.move_valid = 1'b1; mif5.player = p;
      mif5.data_in_x = 3'(x); mif5.data_in_y = 3'(y);
    end else begin
      mif3.move_valid = 1'b1; mif3.player = p;
      mif3.data_in_x = 2'(x); mif3.data_in_y = 2'(y);
    end
    @(posedge clk);
    #1;
    mif5.move_valid = 1'b0;
    mif3.move_valid = 1'b0;
  endtask

  task automatic wait_idle(input int d, input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bsy(d)) return;
    end
    chk({name, ".busy_timeout"}, 1, 0);
  endtask

  task automatic do_move(input int d, input bit p, input int x, input int y, input string name,
                         input bit is_err, input logic [1:0] win, input bit stp, input bit trn);
    exp_t e;
    e.name = name; e.is_err = is_err; e.winner = win; e.stop = stp; e.turn = trn;
    e.max_busy = (d == 0) ? 24 : 16;
    send_move(d, p, x, y, 1'b1, e);
    wait_idle(d, name);
  endtask

  task automatic rd5(input int x, input int y, input int exp, input string name);
    rdx5 = 3'(x);
    rdy5 = 3'(y);
    #1;
    chk(name, int'(rdc5), exp);
  endtask

  function automatic int occupied5();
    int n = 0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        if (u_dut5.u_board.game_state[i][j] != CELL_EMPTY) n++;
    return n;
  endfunction

  // A move offered after game over must be ignored
  task automatic try_after_over(input bit p, input int x, input int y, input string name);
    @(negedge clk);
    chk({name, ".move_ready"}, int'(mif5.move_ready), 0);
    mif5.move_valid = 1'b1; mif5.player = p;
    mif5.data_in_x = 3'(x); mif5.data_in_y = 3'(y);
    repeat (3) @(posedge clk);
    #1;
    mif5.move_valid = 1'b0;
    rd5(x, y, 0, {name, ".cell"});
  endtask

  task automatic pulse_ng5();
    @(posedge clk);
    #1 ng5 = 1'b1;
    @(posedge clk);
    #1 ng5 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst5_n = 1'b0; rst3_n = 1'b0; en5 = 1'b1; en3 = 1'b1; ng5 = 1'b0; ng3 = 1'b0;
    mif5.move_valid = 1'b0; mif5.player = 1'b0; mif5.data_in_x = '0; mif5.data_in_y = '0;
    mif3.move_valid = 1'b0; mif3.player = 1'b0; mif3.data_in_x = '0; mif3.data_in_y = '0;
    rdx5 = '0; rdy5 = '0; rdx3 = '0; rdy3 = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst.move_ready", int'(mif5.move_ready), 0);
    chk("rst.busy", int'(busy5), 0);
    chk("rst.winner", int'(win5), 2);
    chk("rst.stop_game", int'(stop5), 0);
    chk("rst.turn", int'(turn5), 0);
    chk("rst.move_err", int'(mif5.move_err), 0);
    @(posedge clk);
    #1 rst5_n = 1'b1; rst3_n = 1'b1;
    @(negedge clk);
    chk("idle_cycle.move_ready", int'(mif5.move_ready), 0);
    @(negedge clk);
    chk("after_idle.move_ready", int'(mif5.move_ready), 1);

    // Row win for P0 with illegal moves and an enable pause mixed in
    do_move(0, 1'b0, 2, 0, "row_p0_a", 1'b0, W_NONE, 1'b0, 1'b1);
    do_move(0, 1'b1, 2, 0, "ill_occupied", 1'b1, W_NONE, 1'b0, 1'b1);
    do_move(0, 1'b0, 1, 1, "ill_wrong_player", 1'b1, W_NONE, 1'b0, 1'b1);
    do_move(0, 1'b1, 5, 0, "ill_x5", 1'b1, W_NONE, 1'b0, 1'b1);
    rd5(2, 0, 1, "ill.cell_2_0");
    rd5(1, 1, 0, "ill.cell_1_1");
    chk("ill.occupancy", occupied5(), 1);

    e.name = "row_p1_a"; e.is_err = 1'b0; e.winner = W_NONE; e.stop = 1'b0;
    e.turn = 1'b0; e.max_busy = 24;
    send_move(0, 1'b1, 0, 0, 1'b1, e);
    en5 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("en_low%0d.busy", i), int'(busy5), 1);
      chk($sformatf("en_low%0d.move_ready", i), int'(mif5.move_ready), 0);
    end
    chk("en_low.turn", int'(turn5), 1);
    chk("en_low.winner", int'(win5), 2);
    chk("en_low.stop_game", int'(stop5), 0);
    chk("en_low.move_err", int'(mif5.move_err), 0);
    rd5(0, 0, 2, "en_low.cell_0_0");
    @(posedge clk);
    #1 en5 = 1'b1;
    wait_idle(0, "row_p1_a");

    do_move(0, 1'b0, 2, 1, "row_p0_b", 1'b0, W_NONE, 1'b0, 1'b1);
    do_move(0, 1'b1, 0, 1, "row_p1_b", 1'b0, W_NONE, 1'b0, 1'b0);
    do_move(0, 1'b0, 2, 2, "row_p0_c", 1'b0, W_NONE, 1'b0, 1'b1);
    do_move(0, 1'b1, 0, 2, "row_p1_c", 1'b0, W_NONE, 1'b0, 1'b0);
    do_move(0, 1'b0, 2, 3, "row_p0_win", 1'b0, W_P0, 1'b1, 1'b0);
    try_after_over(1'b1, 3, 3, "row_over");
    chk("row_over.winner", int'(win5), 0);

    // new_game, then an anti-diagonal win for P1
    pulse_ng5();
    @(negedge clk);
    chk("ng.winner", int'(win5), 2);
    chk("ng.turn", int'(turn5), 0);
    chk("ng.stop_game", int'(stop5), 0);
    chk("ng.occupancy", occupied5(), 0);
    do_move(0, 1'b0, 4, 4, "ng_first", 1'b0, W_NONE, 1'b0, 1'b1);
    do_move(0, 1'b1, 0, 4, "anti_p1_a", 1'b0, W_NONE, 1'b0, 1'b0);
    do_move(0, 1'b0, 4, 0, "anti_p0_a", 1'b0, W_NONE, 1'b0, 1'b1);
    do_move(0, 1'b1, 1, 3, "anti_p1_b", 1'b0, W_NONE, 1'b0, 1'b0);
    do_move(0, 1'b0, 3, 3, "anti_p0_b", 1'b0, W_NONE, 1'b0, 1'b1);
    do_move(0, 1'b1, 2, 2, "anti_p1_c", 1'b0, W_NONE, 1'b0, 1'b0);
    do_move(0, 1'b0, 4, 2, "anti_p0_c", 1'b0, W_NONE, 1'b0, 1'b1);
    do_move(0, 1'b1, 3, 1, "anti_p1_win", 1'b0, W_P1, 1'b1, 1'b1);
    try_after_over(1'b0, 1, 1, "anti_over");
    chk("anti_over.winner", int'(win5), 1);
    chk("anti_over.occupancy", occupied5(), 8);

    // Reset asserted while a check is running
    pulse_ng5();
    e.name = "rst_in_check";
    send_move(0, 1'b0, 2, 2, 1'b0, e);
    repeat (2) @(posedge clk);
    #2;
    chk("pre_rst.busy", int'(busy5), 1);
    rst5_n = 1'b0;
    #1;
    chk("rst_chk.busy", int'(busy5), 0);
    chk("rst_chk.move_ready", int'(mif5.move_ready), 0);
    chk("rst_chk.winner", int'(win5), 2);
    chk("rst_chk.turn", int'(turn5), 0);
    chk("rst_chk.stop_game", int'(stop5), 0);
    chk("rst_chk.move_err", int'(mif5.move_err), 0);
    chk("rst_chk.occupancy", occupied5(), 0);
    chk("rst_chk.occ_cnt", int'(u_dut5.occ_q), 0);
    rd5(2, 2, 0, "rst_chk.cell_2_2");
    @(posedge clk);
    @(posedge clk);
    #1 rst5_n = 1'b1;
    @(negedge clk);
    chk("rst_rel.idle_ready", int'(mif5.move_ready), 0);
    do_move(0, 1'b0, 0, 0, "post_rst", 1'b0, W_NONE, 1'b0, 1'b1);

    // 3x3 draw: X O X / X X O / O X O
    do_move(1, 1'b0, 0, 0, "draw1", 1'b0, W_NONE, 1'b0, 1'b1);
    do_move(1, 1'b1, 0, 1, "draw2", 1'b0, W_NONE, 1'b0, 1'b0);
    do_move(1, 1'b0, 0, 2, "draw3", 1'b0, W_NONE, 1'b0, 1'b1);
    do_move(1, 1'b1, 1, 2, "draw4", 1'b0, W_NONE, 1'b0, 1'b0);
    do_move(1, 1'b0, 1, 0, "draw5", 1'b0, W_NONE, 1'b0, 1'b1);
    do_move(1, 1'b1, 2, 0, "draw6", 1'b0, W_NONE, 1'b0, 1'b0);
    do_move(1, 1'b0, 1, 1, "draw7", 1'b0, W_NONE, 1'b0, 1'b1);
    do_move(1, 1'b1, 2, 2, "draw8", 1'b0, W_NONE, 1'b0, 1'b0);
    do_move(1, 1'b0, 2, 1, "draw9", 1'b0, W_DRAW, 1'b1, 1'b0);
    rdx3 = 2'd1; rdy3 = 2'd2;
    #1;
    chk("draw.cell_1_2", int'(rdc3), 2);

    repeat (5) @(negedge clk);
    chk("sb5.leftover", sb5.size(), 0);
    chk("sb3.leftover", sb3.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ttt_nxn_fsm.md
TTT_NXN_FSM -- requirements
Module: ttt_nxn_fsm

Interface
REQ-001 SHALL have parameter N, default 3, meaning board edge length, legal range 3..8.
REQ-002 SHALL have parameter K, default 3, meaning win run length, legal range 3..N; elaboration SHALL fail outside these ranges.
REQ-003 SHALL have a localparam CW = $clog2(N), the coordinate width.
REQ-004 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port: enable  input  1  FSM advances only while high.
REQ-007 SHALL have port: new_game  input  1  synchronous board clear, one-cycle pulse.
REQ-008 SHALL have port: move_valid  input  1  move offered.
REQ-009 SHALL have port: move_ready  output  1  block accepts a move this cycle.
REQ-010 SHALL have port: player  input  1  mover ID, 0 or 1.
REQ-011 SHALL have ports: data_in_x, data_in_y  input  CW  row and column of the move.
REQ-012 SHALL have port: move_err  output  1  one-cycle pulse marking a rejected move.
REQ-013 SHALL have port: turn  output  1  player expected next.
REQ-014 SHALL have port: busy  output  1  high while a win check is running.
REQ-015 SHALL have port: winner  output  2  0 = player 0, 1 = player 1, 2 = none, 3 = draw.
REQ-016 SHALL have port: stop_game  output  1  game over.
REQ-017 SHALL have ports: rd_x, rd_y  input  CW; rd_cell  output  2  combinational board readout.

Function
REQ-018 Cell encoding SHALL be: 0 = empty, 1 = player 0, 2 = player 1.
REQ-019 The FSM SHALL have states S_IDLE, S_WAIT_MOVE, S_CHECK and S_DONE.
REQ-020 S_IDLE SHALL go to S_WAIT_MOVE on the first cycle with enable high.
REQ-021 Whenever enable is low, the FSM SHALL hold its state and all counters, and move_ready SHALL be 0.
REQ-022 move_ready SHALL be 1 only in S_WAIT_MOVE with enable high; a move is accepted on move_valid && move_ready.
REQ-023 A move SHALL be rejected if any of these hold: a coordinate is >= N; the cell is not empty; player != turn.
REQ-024 On a rejected move: move_err = 1 for exactly the next cycle, board unchanged, turn unchanged, FSM stays in S_WAIT_MOVE.
REQ-025 On a legal move, the cell SHALL be written on the accept edge, the occupancy counter incremented, and the FSM SHALL go to S_CHECK.
REQ-026 S_CHECK SHALL scan 4 directions in order: row, column, diagonal, anti-diagonal.
REQ-027 For each direction, S_CHECK SHALL step outward from the placed cell on the + side and then the - side, one cell per cycle, at most K-1 steps per side.
REQ-028 A side scan SHALL stop at the board edge or at the first cell not owned by the mover.
REQ-029 For each direction, run = 1 + both side counts.
REQ-030 When run >= K, the scan SHALL terminate at once with winner = mover.
REQ-031 Worst-case check latency SHALL be 8*(K-1) cycles; busy SHALL be high for exactly the cycles spent in S_CHECK.
REQ-032 If no win is found and occupancy == N*N, the result SHALL be winner = 3.
REQ-033 If no win is found and the board is not full, turn SHALL toggle and the FSM SHALL return to S_WAIT_MOVE.
REQ-034 On a win or draw: S_DONE, stop_game = 1, move_ready = 0; winner and the board SHALL be held until new_game or reset.
REQ-035 A winning final placement SHALL report the win, not a draw.
REQ-036 new_game, in any state, SHALL clear the board, occupancy and move_err, and set winner = 2, turn = 0, stop_game = 0, state = S_WAIT_MOVE; it overrides a simultaneous move.

Reset
REQ-037 reset low SHALL asynchronously force: state S_IDLE, board all empty, occupancy 0, turn 0, winner 2, stop_game 0, move_err 0, busy 0, move_ready 0.
REQ-038 Assertion of reset during S_CHECK SHALL abort the check with no partial update surviving.
REQ-039 Deassertion of reset SHALL be followed by one S_IDLE cycle before any move is accepted.

Structure
REQ-040 Package ttt_pkg SHALL hold: the state enum, the cell_t encoding, the winner codes (W_P0, W_P1, W_NONE, W_DRAW), and the direction step table (dx, dy per direction).
REQ-041 Sub-module ttt_board SHALL hold the N×N cell storage with one write port, one scan read port, and the rd_x/rd_y debug read port.
REQ-042 The storage array SHALL be named game_state so that benches can access it hierarchically.

Verification (N=5, K=4 unless stated)
REQ-043 Row win: P0 plays (2,0),(2,1),(2,2),(2,3) interleaved with P1 plays (0,0),(0,1),(0,2) -> winner = 0, stop_game = 1, busy <= 24 cycles per move.
REQ-044 Anti-diagonal win: P1 completes (0,4),(1,3),(2,2),(3,1) -> winner = 1, stop_game = 1; a further move gives move_ready = 0 and no board change.
REQ-045 Illegal moves: occupied cell, wrong player, and x = 5 -> move_err pulses once each, turn unchanged, rd_cell unchanged.
REQ-046 Draw: N=3, K=3, sequence X O X / X X O / O X O -> winner = 3, stop_game = 1 after the 9th move.
REQ-047 Enable and reset: enable low mid-game holds all outputs for 10 cycles; reset asserted during S_CHECK then released -> all outputs equal their reset values and the board is empty.
REQ-048 new_game after a win -> winner = 2, turn = 0, board empty, and the next legal move is accepted.
